// File: rtl/fft_spectrum_peak.sv
// fft_spectrum_peak: alpha-max-beta-min magnitude of streamed FFT bins, a
// positive-frequency spectrum buffer, and a per-frame peak (non-DC) detector.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   rd_en                           input bin valid
//   out_fft_data_re/_im             signed complex bin
//   fft_sop / fft_eop               frame markers, qualified by rd_en
//   spec_rd_addr / spec_rd_data     spectrum buffer read port (1-cycle latency)
//   peak_bin / peak_mag             strongest bin in 1..FFT_LEN/2-1 of last good frame
//   frame_done / frame_err          one-cycle status pulses
//   frame_cnt                       good-frame counter (wraps)
module fft_spectrum_peak #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FFT_LEN    = 256,
    parameter int unsigned BIN_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rd_en,
    input  logic [DATA_WIDTH-1:0]  out_fft_data_re,
    input  logic [DATA_WIDTH-1:0]  out_fft_data_im,
    input  logic                   fft_sop,
    input  logic                   fft_eop,
    input  logic [BIN_WIDTH-2:0]   spec_rd_addr,
    output logic [DATA_WIDTH:0]    spec_rd_data,
    output logic [BIN_WIDTH-1:0]   peak_bin,
    output logic [DATA_WIDTH:0]    peak_mag,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic [15:0]            frame_cnt
);

    localparam int unsigned HALF   = FFT_LEN / 2;
    localparam int unsigned ADDR_W = BIN_WIDTH - 1;
    localparam int unsigned MAG_W  = DATA_WIDTH + 1;

    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [BIN_WIDTH-1:0]  LAST_BIN = BIN_WIDTH'(FFT_LEN - 1);
    localparam logic [BIN_WIDTH-1:0]  BIN_ONE  = BIN_WIDTH'(1);

    typedef enum logic {ST_IDLE, ST_COLLECT} state_t;

    state_t                 state_q, state_d;
    logic [BIN_WIDTH-1:0]   bin_q, bin_d;

    // Pipeline stage 1: absolute values
    logic                   s1_valid_q, s1_valid_d;
    logic                   s1_last_q, s1_last_d;
    logic [BIN_WIDTH-1:0]   s1_bin_q, s1_bin_d;
    logic [DATA_WIDTH-1:0]  abs_re_q, abs_re_d;
    logic [DATA_WIDTH-1:0]  abs_im_q, abs_im_d;
    // Pipeline stage 2: max / min
    logic                   s2_valid_q, s2_valid_d;
    logic                   s2_last_q, s2_last_d;
    logic [BIN_WIDTH-1:0]   s2_bin_q, s2_bin_d;
    logic [DATA_WIDTH-1:0]  hi_q, hi_d;
    logic [DATA_WIDTH-1:0]  lo_q, lo_d;
    // Pipeline stage 3: magnitude
    logic                   s3_valid_q, s3_valid_d;
    logic                   s3_last_q, s3_last_d;
    logic [BIN_WIDTH-1:0]   s3_bin_q, s3_bin_d;
    logic [MAG_W-1:0]       mag_q, mag_d;

    // Running peak search and published results
    logic [BIN_WIDTH-1:0]   run_bin_q, run_bin_d;
    logic [MAG_W-1:0]       run_mag_q, run_mag_d;
    logic [BIN_WIDTH-1:0]   peak_bin_q, peak_bin_d;
    logic [MAG_W-1:0]       peak_mag_q, peak_mag_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [MAG_W-1:0]       rd_data_q;

    logic                   ram_we_c;
    logic [ADDR_W-1:0]      ram_addr_c;
    logic [MAG_W-1:0]       spec_mem [HALF];

    // Frame-tracking FSM, datapath and peak search next-state logic
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        s1_valid_d = 1'b0;
        s1_last_d  = 1'b0;
        s1_bin_d   = '0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rd_en && fft_sop) begin
                    s1_valid_d = 1'b1;
                    if (fft_eop) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_COLLECT;
                        bin_d   = BIN_ONE;
                    end
                end
            end
            ST_COLLECT: begin
                if (rd_en) begin
                    s1_valid_d = 1'b1;
                    if (fft_sop) begin
                        // Restart: this sample becomes bin 0 of a new frame
                        err_d = 1'b1;
                        bin_d = BIN_ONE;
                    end else begin
                        s1_bin_d = bin_q;
                        if (fft_eop) begin
                            state_d = ST_IDLE;
                            bin_d   = '0;
                            if (bin_q == LAST_BIN) begin
                                s1_last_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else if (bin_q == LAST_BIN) begin
                            state_d = ST_IDLE;
                            bin_d   = '0;
                            err_d   = 1'b1;
                        end else begin
                            bin_d = bin_q + BIN_ONE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                bin_d   = '0;
            end
        endcase

        // Absolute value with saturation of the most negative code
        if (out_fft_data_re == MOST_NEG) begin
            abs_re_d = MOST_POS;
        end else if (out_fft_data_re[DATA_WIDTH-1]) begin
            abs_re_d = -out_fft_data_re;
        end else begin
            abs_re_d = out_fft_data_re;
        end
        if (out_fft_data_im == MOST_NEG) begin
            abs_im_d = MOST_POS;
        end else if (out_fft_data_im[DATA_WIDTH-1]) begin
            abs_im_d = -out_fft_data_im;
        end else begin
            abs_im_d = out_fft_data_im;
        end

        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_last_q;
        s2_bin_d   = s1_bin_q;
        hi_d       = (abs_re_q >= abs_im_q) ? abs_re_q : abs_im_q;
        lo_d       = (abs_re_q >= abs_im_q) ? abs_im_q : abs_re_q;

        s3_valid_d = s2_valid_q;
        s3_last_d  = s2_last_q;
        s3_bin_d   = s2_bin_q;
        mag_d      = MAG_W'(hi_q) + MAG_W'(lo_q >> 1);

        // Lower-half bins go to the spectrum buffer
        ram_we_c   = s3_valid_q && !s3_bin_q[BIN_WIDTH-1];
        ram_addr_c = s3_bin_q[ADDR_W-1:0];

        // Bin 1 seeds the search; later lower-half bins win only if strictly larger
        run_bin_d = run_bin_q;
        run_mag_d = run_mag_q;
        if (s3_valid_q && !s3_bin_q[BIN_WIDTH-1]) begin
            if (s3_bin_q == BIN_ONE) begin
                run_bin_d = s3_bin_q;
                run_mag_d = mag_q;
            end else if (s3_bin_q != '0 && mag_q > run_mag_q) begin
                run_bin_d = s3_bin_q;
                run_mag_d = mag_q;
            end
        end

        // The eop bin is upper-half, so the running result is already final here
        peak_bin_d = peak_bin_q;
        peak_mag_d = peak_mag_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        if (s3_valid_q && s3_last_q) begin
            peak_bin_d = run_bin_q;
            peak_mag_d = run_mag_q;
            cnt_d      = cnt_q + 16'd1;
            done_d     = 1'b1;
        end
    end

    // State, pipeline and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_bin_q   <= '0;
            abs_re_q   <= '0;
            abs_im_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_bin_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            s3_valid_q <= 1'b0;
            s3_last_q  <= 1'b0;
            s3_bin_q   <= '0;
            mag_q      <= '0;
            run_bin_q  <= '0;
            run_mag_q  <= '0;
            peak_bin_q <= '0;
            peak_mag_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_bin_q   <= s1_bin_d;
            abs_re_q   <= abs_re_d;
            abs_im_q   <= abs_im_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_bin_q   <= s2_bin_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            s3_valid_q <= s3_valid_d;
            s3_last_q  <= s3_last_d;
            s3_bin_q   <= s3_bin_d;
            mag_q      <= mag_d;
            run_bin_q  <= run_bin_d;
            run_mag_q  <= run_mag_d;
            peak_bin_q <= peak_bin_d;
            peak_mag_q <= peak_mag_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Spectrum buffer storage (contents are not reset)
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            spec_mem[ram_addr_c] <= mag_q;
        end
    end

    // Registered read port; same-cycle write returns the old word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= spec_mem[spec_rd_addr];
        end
    end

    assign spec_rd_data = rd_data_q;
    assign peak_bin     = peak_bin_q;
    assign peak_mag     = peak_mag_q;
    assign frame_done   = done_q;
    assign frame_err    = err_q;
    assign frame_cnt    = cnt_q;

endmodule

// File: tb/tb_fft_spectrum_peak.sv
// Directed self-checking bench for fft_spectrum_peak (DATA_WIDTH=32, FFT_LEN=256).
module tb_fft_spectrum_peak;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] re = '0;
    logic [31:0] im = '0;
    logic        sop = 1'b0;
    logic        eop = 1'b0;
    logic [6:0]  rd_addr = '0;
    logic [32:0] rd_data;
    logic [7:0]  peak_bin;
    logic [32:0] peak_mag;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] frame_cnt;

    fft_spectrum_peak #(.DATA_WIDTH(32), .FFT_LEN(256), .BIN_WIDTH(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rd_en           (rd_en),
        .out_fft_data_re (re),
        .out_fft_data_im (im),
        .fft_sop         (sop),
        .fft_eop         (eop),
        .spec_rd_addr    (rd_addr),
        .spec_rd_data    (rd_data),
        .peak_bin        (peak_bin),
        .peak_mag        (peak_mag),
        .frame_done      (frame_done),
        .frame_err       (frame_err),
        .frame_cnt       (frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] re_arr [256];
    logic [31:0] im_arr [256];
    int          eop_cyc;

    int n_done = 0;
    int n_err  = 0;
    int last_err_cyc = -1;
    int done_cyc [16];
    int done_bin [16];

    always @(negedge clk) begin
        if (frame_done) begin
            if (n_done < 16) begin
                done_cyc[n_done] = cyc;
                done_bin[n_done] = int'(peak_bin);
            end
            n_done++;
        end
        if (frame_err) begin
            last_err_cyc = cyc;
            n_err++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_frame();
        for (int b = 0; b < 256; b++) begin
            re_arr[b] = '0;
            im_arr[b] = '0;
        end
    endtask

    // Drive bins 0..last_b; eop on last_b when with_eop; optional one-cycle gaps
    task automatic send_frame(input int last_b, input bit with_eop, input bit gapped);
        for (int b = 0; b <= last_b; b++) begin
            if (gapped && b > 0) begin
                @(posedge clk); #1;
                rd_en = 1'b0; sop = 1'b0; eop = 1'b0;
            end
            @(posedge clk); #1;
            rd_en = 1'b1;
            re    = re_arr[b];
            im    = im_arr[b];
            sop   = (b == 0);
            eop   = with_eop && (b == last_b);
            if (eop) eop_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rd_en = 1'b0; sop = 1'b0; eop = 1'b0;
        end
    endtask

    task automatic rd(input logic [6:0] a, output logic [32:0] d);
        @(posedge clk); #1;
        rd_addr = a;
        @(posedge clk); #1;
        d = rd_data;
    endtask

    logic [32:0] d;
    int          done_before;
    int          err_before;
    int          eop_a;

    initial begin
        clear_frame();
        #12;
        // Reset state
        chk("rst_peak_bin", 64'(peak_bin), 64'd0);
        chk("rst_peak_mag", 64'(peak_mag), 64'd0);
        chk("rst_done",     64'(frame_done), 64'd0);
        chk("rst_err",      64'(frame_err), 64'd0);
        chk("rst_cnt",      64'(frame_cnt), 64'd0);
        chk("rst_rd_data",  64'(rd_data), 64'd0);
        rst_n = 1'b1;
        idle(3);

        // Single tone, contiguous
        clear_frame();
        re_arr[0]  = 32'd5000;
        re_arr[10] = 32'd1000;
        im_arr[10] = -32'sd400;
        send_frame(255, 1'b1, 1'b0);
        idle(6);
        chk("tone_ndone",    64'(n_done), 64'd1);
        chk("tone_done_lat", 64'(done_cyc[0] - eop_cyc), 64'd4);
        chk("tone_peak_bin", 64'(peak_bin), 64'd10);
        chk("tone_peak_mag", 64'(peak_mag), 64'd1200);
        chk("tone_cnt",      64'(frame_cnt), 64'd1);
        chk("tone_nerr",     64'(n_err), 64'd0);
        rd(7'd10, d);
        chk("tone_rd10", 64'(d), 64'd1200);
        rd(7'd0, d);
        chk("tone_rd0",  64'(d), 64'd5000);
        rd(7'd11, d);
        chk("tone_rd11", 64'(d), 64'd0);

        // Tie and saturation
        clear_frame();
        re_arr[3] = 32'h8000_0000;
        re_arr[7] = 32'h8000_0000;
        send_frame(255, 1'b1, 1'b0);
        idle(6);
        chk("tie_peak_bin", 64'(peak_bin), 64'd3);
        chk("tie_peak_mag", 64'(peak_mag), 64'h7FFF_FFFF);
        chk("tie_cnt",      64'(frame_cnt), 64'd2);
        rd(7'd3, d);
        chk("tie_rd3", 64'(d), 64'h7FFF_FFFF);
        rd(7'd7, d);
        chk("tie_rd7", 64'(d), 64'h7FFF_FFFF);

        // Gapped single tone
        clear_frame();
        re_arr[0]  = 32'd5000;
        re_arr[10] = 32'd1000;
        im_arr[10] = -32'sd400;
        send_frame(255, 1'b1, 1'b1);
        idle(6);
        chk("gap_ndone",    64'(n_done), 64'd3);
        chk("gap_done_lat", 64'(done_cyc[2] - eop_cyc), 64'd4);
        chk("gap_peak_bin", 64'(peak_bin), 64'd10);
        chk("gap_peak_mag", 64'(peak_mag), 64'd1200);
        chk("gap_cnt",      64'(frame_cnt), 64'd3);

        // Short frame: eop on bin 100
        clear_frame();
        re_arr[50] = 32'd9999;
        done_before = n_done;
        send_frame(100, 1'b1, 1'b0);
        idle(8);
        chk("short_nerr",     64'(n_err), 64'd1);
        chk("short_err_lat",  64'(last_err_cyc - eop_cyc), 64'd1);
        chk("short_ndone",    64'(n_done), 64'(done_before));
        chk("short_peak_bin", 64'(peak_bin), 64'd10);
        chk("short_peak_mag", 64'(peak_mag), 64'd1200);
        chk("short_cnt",      64'(frame_cnt), 64'd3);

        // Good frame after the error
        clear_frame();
        re_arr[60] = 32'd3000;
        im_arr[60] = 32'd3000;
        send_frame(255, 1'b1, 1'b0);
        idle(6);
        chk("rec_peak_bin", 64'(peak_bin), 64'd60);
        chk("rec_peak_mag", 64'(peak_mag), 64'd4500);
        chk("rec_cnt",      64'(frame_cnt), 64'd4);
        chk("rec_nerr",     64'(n_err), 64'd1);

        // Back-to-back frames: peak at bin 20 then bin 90
        done_before = n_done;
        clear_frame();
        re_arr[20] = -32'sd700;
        send_frame(255, 1'b1, 1'b0);
        eop_a = eop_cyc;
        clear_frame();
        re_arr[90] = 32'd100;
        im_arr[90] = -32'sd2000;
        send_frame(255, 1'b1, 1'b0);
        idle(6);
        chk("b2b_ndone",    64'(n_done - done_before), 64'd2);
        chk("b2b_lat_a",    64'(done_cyc[done_before] - eop_a), 64'd4);
        chk("b2b_spacing",  64'(done_cyc[done_before+1] - done_cyc[done_before]), 64'd256);
        chk("b2b_bin_a",    64'(done_bin[done_before]), 64'd20);
        chk("b2b_bin_b",    64'(peak_bin), 64'd90);
        chk("b2b_mag_b",    64'(peak_mag), 64'd2050);
        chk("b2b_cnt",      64'(frame_cnt), 64'd6);
        chk("b2b_nerr",     64'(n_err), 64'd1);

        // Reset mid-frame at bin 50
        err_before = n_err;
        clear_frame();
        re_arr[20] = 32'd4444;
        send_frame(49, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        rd_en = 1'b0; sop = 1'b0; eop = 1'b0;
        #2;
        chk("mrst_peak_bin", 64'(peak_bin), 64'd0);
        chk("mrst_peak_mag", 64'(peak_mag), 64'd0);
        chk("mrst_cnt",      64'(frame_cnt), 64'd0);
        chk("mrst_done",     64'(frame_done), 64'd0);
        chk("mrst_err",      64'(frame_err), 64'd0);
        chk("mrst_rd_data",  64'(rd_data), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(3);
        chk("mrst_nerr", 64'(n_err), 64'(err_before));

        clear_frame();
        re_arr[30] = 32'd555;
        send_frame(255, 1'b1, 1'b0);
        idle(6);
        chk("post_peak_bin", 64'(peak_bin), 64'd30);
        chk("post_peak_mag", 64'(peak_mag), 64'd555);
        chk("post_cnt",      64'(frame_cnt), 64'd1);
        chk("post_nerr",     64'(n_err), 64'(err_before));
        rd(7'd30, d);
        chk("post_rd30", 64'(d), 64'd555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
